regfile_bank: RTL



---
 rtl/regfile_bank_pkg.sv | 12 +
 rtl/regfile_bank_reg_cell.sv | 28 ++
 rtl/regfile_bank.sv | 106 ++++++++++
 3 files changed

// File: rtl/regfile_bank_pkg.sv
// Shared constants for the MIPS register file storage array, its write
// decode and the downstream 32:1 read-port selectors.
package regfile_bank_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;
   localparam int WCNT_W   = 16;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : regfile_bank_pkg

// File: rtl/regfile_bank_reg_cell.sv
// One architectural register: DATA_W-wide storage with a load enable and a
// synchronous active-high clear. Reset has priority over load.
module reg_cell
   import regfile_bank_pkg::*;
#(
   parameter int CELL_W = DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_ld,
   input  logic [CELL_W-1:0] i_d,
   output logic [CELL_W-1:0] o_q
);

   logic [CELL_W-1:0] r_q;

   // Clear on reset, otherwise capture new data when selected by the decode.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q <= '0;
      end else if (i_ld) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule : reg_cell

// File: rtl/regfile_bank.sv
// MIPS register file storage: 31 writable registers plus a hardwired zero
// register, exposed on a flattened bus for the rs/rt read selectors.
// Also tracks per-register dirty bits, an accepted-write counter and a
// one-cycle write acknowledge.
// Optional build macro: REGFILE_WR_BYPASS_EN -- when defined, the slice
// being written shows Din combinationally in the same cycle.
module regfile_bank
#(
   parameter int DATA_W   = regfile_bank_pkg::DATA_W,
   parameter int NUM_REGS = regfile_bank_pkg::NUM_REGS,
   parameter int ADDR_W   = regfile_bank_pkg::ADDR_W,
   parameter int WCNT_W   = regfile_bank_pkg::WCNT_W
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic                       WrEn,
   input  logic [ADDR_W-1:0]          Awr,
   input  logic [DATA_W-1:0]          Din,
   output logic [NUM_REGS*DATA_W-1:0] dout_flat,
   output logic [NUM_REGS-1:0]        dirty,
   output logic [WCNT_W-1:0]          wr_count,
   output logic                       wr_ack
);

   import regfile_bank_pkg::*;

   // One-hot write decode for registers 1..NUM_REGS-1; register 0 has no
   // load enable, so a write to it naturally decodes to nothing.
   logic [NUM_REGS-1:1] w_dec;
   logic                w_wr_acc;

   logic [NUM_REGS-1:1] r_dirty;
   logic [WCNT_W-1:0]   r_wr_count;
   logic                r_wr_ack;

   // Decode Awr into per-register load enables, gated by WrEn.
   always_comb begin
      w_dec = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         w_dec[i] = WrEn && (Awr == ADDR_W'(i));
      end
   end

   // A write is accepted exactly when it hits a writable register.
   assign w_wr_acc = |w_dec;

   // Register zero reads as constant zero.
   assign dout_flat[DATA_W-1:0] = '0;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
      logic [DATA_W-1:0] w_q;

      reg_cell #(
         .CELL_W (DATA_W)
      ) u_cell (
         .i_clk (Clk),
         .i_rst (Rst),
         .i_ld  (w_dec[g]),
         .i_d   (Din),
         .o_q   (w_q)
      );

`ifdef REGFILE_WR_BYPASS_EN
      // Forward write data so a same-cycle read sees the new value.
      assign dout_flat[DATA_W*g +: DATA_W] = (w_dec[g] && !Rst) ? Din : w_q;
`else
      assign dout_flat[DATA_W*g +: DATA_W] = w_q;
`endif
   end

   // Mark registers written since reset; dirty[0] can never be set.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_dirty <= '0;
      end else begin
         r_dirty <= r_dirty | w_dec;
      end
   end

   // Count accepted writes; wraps silently at all-ones.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_wr_count <= '0;
      end else if (w_wr_acc) begin
         r_wr_count <= r_wr_count + WCNT_W'(1);
      end
   end

   // Acknowledge is high for the one cycle following an accepted write.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_wr_ack <= 1'b0;
      end else begin
         r_wr_ack <= w_wr_acc;
      end
   end

   assign dirty    = {r_dirty, 1'b0};
   assign wr_count = r_wr_count;
   assign wr_ack   = r_wr_ack;

   // An unknown destination during a write would corrupt an arbitrary register.
   a_awr_known: assert property (@(posedge Clk) disable iff (Rst)
      WrEn |-> !$isunknown(Awr));

endmodule : regfile_bank
